// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep sequencer: state encodings and default widths.
package sweep_ctrl_pkg;

  localparam int unsigned SWEEP_N_DEF     = 8;
  localparam int unsigned SWEEP_CYC_W_DEF = 4;

  // 3-bit state encodings shared with anything that observes the sequencer state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4,
    ST_CLR  = 3'd5
  } sweepStateT;

  // Busy covers every state that owns the counter.
  function automatic logic isBusy(input sweepStateT s);
    return (s == ST_LOAD) || (s == ST_UP) || (s == ST_DOWN) || (s == ST_CLR);
  endfunction

endpackage

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives a univ_bin_counter through LO->HI->LO triangle sweeps, iCYCLES times.
// Ports:
//   iCLK, iRESET            clock, synchronous active-high reset
//   iSTART, iABORT          start request (IDLE only), abort of an active sweep
//   iLO, iHI, iCYCLES       sweep bounds and repeat count, latched on start
//   iQ                      counter value feedback
//   oCLEAR/oLOAD/oEN/oUP/oD counter controls (oD is the latched lower bound)
//   oBUSY, oDONE, oERR      status: sweep active, completion pulse, start-rejected pulse
//   oCYC                    0-based index of the current sweep
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int unsigned N     = SWEEP_N_DEF,
  parameter int unsigned CYC_W = SWEEP_CYC_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iABORT,
  input  logic [N-1:0]     iLO,
  input  logic [N-1:0]     iHI,
  input  logic [CYC_W-1:0] iCYCLES,
  input  logic [N-1:0]     iQ,
  output logic             oCLEAR,
  output logic             oLOAD,
  output logic             oEN,
  output logic             oUP,
  output logic [N-1:0]     oD,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR,
  output logic [CYC_W-1:0] oCYC
);

  sweepStateT       state;
  sweepStateT       nextState;
  logic [N-1:0]     loR;
  logic [N-1:0]     hiR;
  logic [CYC_W-1:0] cycR;
  logic             startBad;
  logic             atTop;
  logic             atBottom;
  logic             lastSweep;

  // A start with an empty range or zero repeats is rejected.
  assign startBad  = (iLO >= iHI) || (iCYCLES == '0);
  // Turn one step early: the counter reaches the bound on the same edge the state changes.
  assign atTop     = (iQ == hiR - N'(1));
  assign atBottom  = (iQ == loR + N'(1));
  assign lastSweep = (oCYC == cycR - CYC_W'(1));

  assign oD = loR;

  // Next-state decode; abort outranks normal sequencing in the counter-owning states.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE: if (iSTART && !startBad) nextState = ST_LOAD;
      ST_LOAD: nextState = iABORT ? ST_CLR : ST_UP;
      ST_UP: begin
        if (iABORT)     nextState = ST_CLR;
        else if (atTop) nextState = ST_DOWN;
      end
      ST_DOWN: begin
        if (iABORT)        nextState = ST_CLR;
        else if (atBottom) nextState = lastSweep ? ST_DONE : ST_UP;
      end
      ST_DONE: nextState = ST_IDLE;
      ST_CLR:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // State, latched operands and registered Moore outputs (decoded from the state being entered).
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state  <= ST_IDLE;
      loR    <= '0;
      hiR    <= '0;
      cycR   <= '0;
      oCYC   <= '0;
      oCLEAR <= 1'b0;
      oLOAD  <= 1'b0;
      oEN    <= 1'b0;
      oUP    <= 1'b0;
      oBUSY  <= 1'b0;
      oDONE  <= 1'b0;
      oERR   <= 1'b0;
    end else begin
      state  <= nextState;
      oCLEAR <= (nextState == ST_CLR);
      oLOAD  <= (nextState == ST_LOAD);
      oEN    <= (nextState == ST_UP) || (nextState == ST_DOWN);
      oUP    <= (nextState == ST_UP);
      oBUSY  <= isBusy(nextState);
      oDONE  <= (nextState == ST_DONE);
      oERR   <= (state == ST_IDLE) && iSTART && startBad;

      if (state == ST_IDLE && iSTART) begin
        loR  <= iLO;
        hiR  <= iHI;
        cycR <= iCYCLES;
        oCYC <= '0;
      end else if (state == ST_DOWN && nextState == ST_UP) begin
        oCYC <= oCYC + CYC_W'(1);
      end
    end
  end

endmodule
